// File: rtl/tinker_regfile_sb.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Reads and busy flags are combinational; writes, issues and counters update at posedge.
module tinker_regfile_sb #(
  parameter int     DATA_W   = 64,
  parameter int     NUM_REGS = 32,
  parameter int     NUM_RD   = 3,
  parameter int     NUM_WR   = 2,
  parameter int     SP_IDX   = 31,
  parameter longint SP_RESET = 524288,
  parameter int     CNT_W    = 2,
  parameter int     BYPASS   = 1,
  parameter int     ZERO_REG = 0,
  localparam int    AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_ready,
  input  logic                     flush,
  output logic [DATA_W-1:0]        sp_val,
  output logic                     err
);

  localparam int DW = $clog2(NUM_WR + 1);
  localparam int SW = CNT_W + DW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs    [NUM_REGS];
  logic [CNT_W-1:0]  pend    [NUM_REGS];
  logic [DW-1:0]     dec_cnt [NUM_REGS];
  logic [NUM_WR-1:0] we_eff;
  logic              iss_zero;
  logic              iss_acc;
  logic              err_hit;
  logic [AW-1:0]     ra;
  logic [DATA_W-1:0] rv;

  // Net counter change, clamped at zero so excess writebacks cannot underflow.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic [DW-1:0] dec);
    logic signed [SW-1:0] net;
    net = $signed(SW'(cur)) + $signed(SW'(inc)) - $signed(SW'(dec));
    return (net > 0) ? CNT_W'(net) : '0;
  endfunction

  function automatic logic busy_after(input logic [CNT_W-1:0] cur,
                                      input logic [DW-1:0] dec);
    logic signed [SW-1:0] net;
    net = $signed(SW'(cur)) - $signed(SW'(dec));
    return net > 0;
  endfunction

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      we_eff[j] = wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      dec_cnt[r] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (we_eff[j] && (wr_addr[j*AW +: AW] == AW'(r))) dec_cnt[r] = dec_cnt[r] + DW'(1);
      end
    end
  end

  assign iss_zero  = (ZERO_REG != 0) && (iss_addr == '0);
  assign iss_ready = iss_zero ? 1'b1 : (!flush && (pend[iss_addr] != CNT_MAX));
  assign iss_acc   = iss_en && iss_ready && !iss_zero;

  // Read ports: later write ports override earlier ones in the bypass path.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rv      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*AW +: AW];
      rv = regs[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (we_eff[j] && (wr_addr[j*AW +: AW] == ra)) rv = wr_data[j*DATA_W +: DATA_W];
        end
        rd_busy[i] = busy_after(pend[ra], dec_cnt[ra]);
      end else begin
        rd_busy[i] = (pend[ra] != '0);
      end
      if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
      rd_data[i*DATA_W +: DATA_W] = rv;
    end
  end

  always_comb begin
    err_hit = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we_eff[j] && (pend[wr_addr[j*AW +: AW]] == '0)) err_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= (r == SP_IDX) ? DATA_W'(SP_RESET) : '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (we_eff[j] && (wr_addr[j*AW +: AW] == AW'(r))) regs[r] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend[r] <= cnt_next(pend[r], iss_acc && (iss_addr == AW'(r)), dec_cnt[r]);
      end
    end
  end

  // Error is judged against the counters before any flush takes effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= err | err_hit;
  end

  assign sp_val = regs[SP_IDX];

endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Bench for tinker_regfile_sb: array/counter model checked every cycle plus directed literals.
module tb_tinker_regfile_sb;

  logic         clk = 1'b0;
  logic         reset;
  logic [14:0]  rd_addr;
  logic [191:0] rd_data, nb_rd_data;
  logic [2:0]   rd_busy, nb_rd_busy;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;
  logic         iss_en;
  logic [4:0]   iss_addr;
  logic         iss_ready, nb_iss_ready;
  logic         flush;
  logic [63:0]  sp_val, nb_sp_val;
  logic         err, nb_err;

  int errors = 0;
  int checks = 0;

  typedef struct { string name; int sel; logic [63:0] val; } lit_t;
  lit_t lit_q[$];

  logic [63:0] m_regs [32];
  int          m_pend [32];
  bit          m_err;

  tinker_regfile_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .flush(flush), .sp_val(sp_val), .err(err)
  );

  tinker_regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ready(nb_iss_ready), .flush(flush), .sp_val(nb_sp_val), .err(nb_err)
  );

  always #5 clk = ~clk;

  function automatic int rda(int i);  return int'(rd_addr[i*5 +: 5]);  endfunction
  function automatic int wa(int j);   return int'(wr_addr[j*5 +: 5]);  endfunction
  function automatic logic [63:0] wd(int j); return wr_data[j*64 +: 64]; endfunction
  function automatic int ndec(int r);
    int n = 0;
    for (int j = 0; j < 2; j++) if (wr_en[j] && wa(j) == r) n++;
    return n;
  endfunction

  // Model state advance: writes land, counters move by issues minus writebacks.
  always @(posedge clk or posedge reset) begin : model_upd
    int  n;
    bit  acc;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] <= (r == 31) ? 64'd524288 : 64'd0;
        m_pend[r] <= 0;
      end
      m_err <= 1'b0;
    end else begin
      acc = iss_en && !flush && (m_pend[iss_addr] != 3);
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j]) begin
          m_regs[wa(j)] <= wd(j);
          if (m_pend[wa(j)] == 0) m_err <= 1'b1;
        end
      end
      for (int r = 0; r < 32; r++) begin
        n = m_pend[r] + ((acc && int'(iss_addr) == r) ? 1 : 0) - ndec(r);
        if (n < 0) n = 0;
        m_pend[r] <= flush ? 0 : n;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] actual(int sel);
    case (sel)
      0, 1, 2: return rd_data[sel*64 +: 64];
      3, 4, 5: return nb_rd_data[(sel-3)*64 +: 64];
      6:       return {61'b0, rd_busy};
      7:       return {61'b0, nb_rd_busy};
      8:       return {63'b0, iss_ready};
      9:       return sp_val;
      10:      return {63'b0, err};
      11:      return {63'b0, nb_err};
      default: return 'x;
    endcase
  endfunction

  task automatic model_cmp();
    logic [63:0] v;
    logic [2:0]  eb, en;
    int a;
    for (int i = 0; i < 3; i++) begin
      a = rda(i);
      v = m_regs[a];
      for (int j = 0; j < 2; j++) if (wr_en[j] && wa(j) == a) v = wd(j);
      chk("model_rd_data", rd_data[i*64 +: 64], v);
      chk("model_nb_rd_data", nb_rd_data[i*64 +: 64], m_regs[a]);
      eb[i] = (m_pend[a] - ndec(a)) > 0;
      en[i] = m_pend[a] != 0;
    end
    chk("model_rd_busy", {61'b0, rd_busy}, {61'b0, eb});
    chk("model_nb_rd_busy", {61'b0, nb_rd_busy}, {61'b0, en});
    chk("model_iss_ready", {63'b0, iss_ready}, {63'b0, !flush && m_pend[iss_addr] != 3});
    chk("model_nb_iss_ready", {63'b0, nb_iss_ready}, {63'b0, !flush && m_pend[iss_addr] != 3});
    chk("model_sp_val", sp_val, m_regs[31]);
    chk("model_nb_sp_val", nb_sp_val, m_regs[31]);
    chk("model_err", {63'b0, err}, {63'b0, m_err});
    chk("model_nb_err", {63'b0, nb_err}, {63'b0, m_err});
  endtask

  // Single compare process: queued literals first, then the model comparison.
  always @(negedge clk) begin
    while (lit_q.size() > 0) begin
      lit_t e;
      e = lit_q.pop_front();
      chk(e.name, actual(e.sel), e.val);
    end
    if (!reset) model_cmp();
  end

  task automatic want(input string n, input int sel, input logic [63:0] v);
    lit_t e;
    e.name = n; e.sel = sel; e.val = v;
    lit_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*5 +: 5] = 5'(a);
  endtask

  task automatic wr(input int j, input int a, input logic [63:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*5 +: 5] = 5'(a);
    wr_data[j*64 +: 64] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    tick();
    // Reset contents
    set_rd(0, 31); set_rd(1, 5); set_rd(2, 0);
    want("rst_r31", 0, 64'd524288); want("rst_r5", 1, 0); want("rst_r0", 2, 0);
    want("rst_sp", 9, 64'd524288); want("rst_busy", 6, 0); want("rst_err", 10, 0);
    want("rst_ready", 8, 1);
    tick();
    reset = 1'b0; idle();
    tick();
    // Write to an idle register flags err, which stays sticky
    wr(0, 12, 64'h1234); want("err_pre", 10, 0);
    tick();
    idle(); want("err_set", 10, 1); want("err_set_nb", 11, 1);
    tick();
    idle(); want("err_hold", 10, 1);
    tick();
    // Bypass and write-port priority
    idle(); wr(0, 7, 64'hDEAD_BEEF); set_rd(0, 7);
    want("byp_r7", 0, 64'hDEAD_BEEF); want("nobyp_r7", 3, 0);
    tick();
    idle(); set_rd(0, 7); want("r7_stored", 0, 64'hDEAD_BEEF); want("r7_stored_nb", 3, 64'hDEAD_BEEF);
    tick();
    idle(); wr(0, 7, 64'h11); wr(1, 7, 64'h22); set_rd(0, 7); want("byp_prio", 0, 64'h22);
    tick();
    idle(); set_rd(0, 7); want("prio_r7", 0, 64'h22); want("prio_r7_nb", 3, 64'h22);
    tick();
    // Asynchronous reset mid-cycle
    idle(); set_rd(0, 7); set_rd(1, 31); reset = 1'b1;
    want("mid_rst_err", 10, 0); want("mid_rst_err_nb", 11, 0);
    want("mid_rst_r7", 0, 0); want("mid_rst_sp", 1, 64'd524288);
    tick();
    reset = 1'b0;
    tick();
    // Issue r3, then writeback
    idle(); iss_en = 1'b1; iss_addr = 5'd3; set_rd(1, 3);
    want("iss3_ready", 8, 1); want("iss3_own_busy", 6, 0);
    tick();
    idle(); set_rd(1, 3); want("r3_busy", 6, 3'b010); want("r3_busy_nb", 7, 3'b010);
    tick();
    idle(); wr(0, 3, 64'h55); set_rd(1, 3);
    want("r3_wb_busy", 6, 0); want("r3_wb_data", 1, 64'h55);
    want("r3_wb_busy_nb", 7, 3'b010); want("r3_wb_data_nb", 4, 0);
    tick();
    idle(); set_rd(1, 3); want("r3_after_nb", 7, 0); want("r3_after_data_nb", 4, 64'h55);
    want("r3_no_err", 10, 0);
    tick();
    // Counter saturation on r4
    idle(); set_rd(2, 4); iss_en = 1'b1; iss_addr = 5'd4;
    for (int k = 0; k < 3; k++) begin
      want("r4_ready", 8, 1);
      tick();
    end
    want("r4_full", 8, 0); want("r4_busy", 6, 3'b100);
    tick();
    idle(); set_rd(2, 4); wr(0, 4, 64'hA1); want("r4_wb1_busy", 6, 3'b100);
    tick();
    idle(); set_rd(2, 4); iss_en = 1'b1; iss_addr = 5'd4; wr(0, 4, 64'hA2);
    want("r4_iss_wr_ready", 8, 1);
    tick();
    idle(); set_rd(2, 4); wr(0, 4, 64'hA3); want("r4_pend2", 6, 3'b100);
    tick();
    idle(); set_rd(2, 4); wr(0, 4, 64'hA4); want("r4_last_busy", 6, 0); want("r4_last_data", 2, 64'hA4);
    tick();
    idle(); want("r4_no_err", 10, 0);
    tick();
    // Flush clears counters and drops the concurrent issue
    idle(); iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    iss_addr = 5'd10;
    tick();
    idle(); set_rd(0, 9); set_rd(1, 10); set_rd(2, 11);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd11;
    want("pre_flush_busy", 6, 3'b011); want("flush_ready", 8, 0);
    tick();
    idle(); set_rd(0, 9); set_rd(1, 10); set_rd(2, 11);
    want("post_flush_busy", 6, 0); want("post_flush_busy_nb", 7, 0);
    tick();
    idle(); wr(0, 11, 64'h5); want("r11_pre_err", 10, 0);
    tick();
    idle(); want("r11_not_pending", 10, 1);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
